// File: rtl/lsu_ctrl.sv
// Load/store controller between the memory stage and a word-wide data memory.
// Sub-word loads are lane-extracted here; sub-word stores become read-modify-write word accesses.
module lsu_ctrl #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic [2:0]    op,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dout,
   output logic [1:0]    dbg_state_o
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SB  = 3'd6;
   localparam logic [2:0] OP_SH  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   // Handshake: req is sampled only while busy is low; completion is a single-cycle
   // done pulse (with err) and there is no back-pressure on the response.
   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [DW-1:0]   merged;

   function automatic logic misaligned(input logic [2:0] o, input logic [1:0] lo);
      case (o)
         OP_LW, OP_SW:          return (lo != 2'b00);
         OP_LH, OP_LHU, OP_SH:  return lo[0];
         default:               return 1'b0;
      endcase
   endfunction

   assign byte_sel = mem_dout[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = mem_dout[{addr_q[1], 4'b0000} +: 16];

   // din_q holds the raw store data until RD, so its low lanes feed the merge.
   always_comb begin
      merged = mem_dout;
      if (op_q == OP_SB) merged[{addr_q[1:0], 3'b000} +: 8] = din_q[7:0];
      else               merged[{addr_q[1], 4'b0000} +: 16] = din_q[15:0];
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d   = op;
               addr_d = addr;
               din_d  = wdata;
               if (misaligned(op, addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (op == OP_SW) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (op_q < OP_SW) begin
               case (op_q)
                  OP_LB:   rdata_d = {{24{byte_sel[7]}}, byte_sel};
                  OP_LBU:  rdata_d = {24'd0, byte_sel};
                  OP_LH:   rdata_d = {{16{half_sel[15]}}, half_sel};
                  OP_LHU:  rdata_d = {16'd0, half_sel};
                  default: rdata_d = mem_dout;
               endcase
               state_d = S_RESP;
            end else begin
               din_d   = merged;
               state_d = S_WR;
            end
         end
         S_WR:   state_d = S_RESP;
         S_RESP: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_LW;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Decoded straight from the state register so an async reset drops mem_we at once.
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_RESP);
   assign mem_we      = (state_q == S_WR);
   assign err         = err_q;
   assign rdata       = rdata_q;
   assign mem_addr    = {addr_q[AW-1:2], 2'b00};
   assign mem_din     = din_q;
   assign dbg_state_o = state_q;

endmodule
